instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter DEPTH, default 32, number of instruction words (pc width 5).
REQ-002 Parameter IW, default 16, instruction width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load_start  input  1  one-cycle pulse requesting a new program load.
REQ-006 load_len  input  6  number of words to load (valid 1..32), sampled with load_start.
REQ-007 in_valid  input  1  upstream byte valid.
REQ-008 in_data  input  8  upstream program byte.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 rom_enable  input  1  fetch strobe from the control FSM.
REQ-011 pc  input  5  fetch address from the PC.
REQ-012 instr  output  16  registered instruction word.
REQ-013 cpu_run  output  1  program loaded; CPU may execute.
REQ-014 busy  output  1  load in progress.
REQ-015 load_err  output  1  last load_start carried an illegal load_len (sticky until next load_start).

Function
REQ-016 The FSM SHALL have states IDLE, RECV_HI, RECV_LO and RUN.
REQ-017 A byte SHALL transfer only on cycles where in_valid && in_ready; in_valid without in_ready SHALL be ignored.
REQ-018 in_ready SHALL be 1 exactly in RECV_HI and RECV_LO; busy SHALL equal in_ready.
REQ-019 In IDLE or RUN, load_start with load_len in 1..32 SHALL latch load_len, clear the word counter, clear load_err, drop cpu_run and enter RECV_HI next cycle.
REQ-020 In IDLE or RUN, load_start with load_len 0 or >32 SHALL set load_err, clear cpu_run and enter IDLE.
REQ-021 load_start in RECV_HI or RECV_LO SHALL be ignored.
REQ-022 In RECV_HI, a transfer SHALL latch in_data as instruction bits [15:8] and move to RECV_LO.
REQ-023 In RECV_LO, a transfer SHALL write {hi_byte, in_data} to mem[word_counter] in the same edge, increment word_counter, and move to RECV_HI.
REQ-024 When the RECV_LO transfer writes word index load_len-1, the next state SHALL be RUN, with cpu_run = 1 from the following cycle.
REQ-025 Bytes are big-endian per word: first byte high, second byte low.
REQ-026 Words at indices >= load_len SHALL retain their previous contents.
REQ-027 In RUN, rom_enable = 1 SHALL load instr <= mem[pc] at that edge, giving 1-cycle read latency.
REQ-028 rom_enable outside RUN, or rom_enable = 0, SHALL leave instr unchanged.
REQ-029 pc is always in range (5 bits, DEPTH 32); no address wrap logic is required.
REQ-030 cpu_run SHALL stay 1 in RUN until the next load_start or rst.

Reset
REQ-031 rst SHALL force state IDLE, in_ready 0, busy 0, cpu_run 0, load_err 0, instr 16'h0000, word_counter 0 and hi_byte 0.
REQ-032 rst SHALL NOT clear memory contents.
REQ-033 rst asserted mid-load SHALL abandon the load; a partial word is never written, and words already written remain.
REQ-034 rst has priority over load_start and byte transfers in the same cycle.

Structure
REQ-035 State encodings (IDLE, RECV_HI, RECV_LO, RUN), DEPTH, IW and max load length 32 SHALL live in the shared CPU package with the control FSM state constants.
REQ-036 Storage SHALL be a sub-module imem_32x16: 1 synchronous write port and 1 registered read port with read enable.
REQ-037 The FSM, counter and byte assembly SHALL stay in instr_mem_loader.

Verification
REQ-038 Load: load_len=2, bytes A1,B2,C3,D4 with in_valid held -> mem[0]=16'hA1B2, mem[1]=16'hC3D4; cpu_run=1 the cycle after the 4th transfer; in_ready=0 afterwards.
REQ-039 Backpressure: toggle in_valid 1/0 on each cycle over the same stream -> identical memory result; no byte is duplicated or dropped.
REQ-040 Fetch: after REQ-038, pc=1 with rom_enable=1 -> instr=16'hC3D4 next cycle; rom_enable=0 with pc=0 -> instr stays 16'hC3D4.
REQ-041 Illegal length: load_start with load_len=0, then with load_len=33 -> load_err=1, state IDLE, in_ready=0, cpu_run=0.
REQ-042 Reset mid-load: rst after 3 bytes of a 2-word load -> cpu_run=0, instr=0, state IDLE; mem[0] holds the new word and mem[1] its old value.
REQ-043 Reload from RUN: load_start with load_len=1, bytes 12,34 -> cpu_run drops next cycle; mem[0]=16'h1234; mem[1] unchanged; cpu_run returns to 1.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared CPU package: instruction memory geometry, loader FSM encodings, control FSM
// encodings and a load-length legality helper.
package instr_mem_loader_pkg;

    // Instruction memory geometry
    localparam int unsigned IMEM_DEPTH   = 32;
    localparam int unsigned IMEM_IW      = 16;
    localparam logic [5:0]  MAX_LOAD_LEN = 6'd32;

    // Loader FSM encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECV_HI = 2'd1;
    localparam logic [1:0] ST_RECV_LO = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    // CPU control FSM encodings, kept here so both FSMs share one definition point
    localparam logic [1:0] CTRL_FETCH   = 2'd0;
    localparam logic [1:0] CTRL_DECODE  = 2'd1;
    localparam logic [1:0] CTRL_EXECUTE = 2'd2;
    localparam logic [1:0] CTRL_HALT    = 2'd3;

    // A load length is usable only if it names at least one word and fits the memory
    function automatic logic load_len_legal(input logic [5:0] len);
        return (len != 6'd0) && (len <= MAX_LOAD_LEN);
    endfunction

endpackage

// File: rtl/imem_32x16.sv
// Instruction storage: one synchronous write port and one registered read port.
// Ports:
//   clk, rst          clock; synchronous active-high reset (clears the read register only)
//   we, waddr, wdata  write port, written on the rising edge when we = 1
//   re, raddr         read enable and address; rdata updates on the edge when re = 1
//   rdata             registered read data, holds its value while re = 0
module imem_32x16
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH,
    parameter int unsigned IW    = IMEM_IW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [IW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [IW-1:0]            rdata
);

    // Array is intentionally not reset so a program survives rst
    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] rdata_q;
    logic [IW-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader for the instruction memory. Receives a byte stream (big-endian
// 16-bit words) over a valid/ready handshake, writes it into imem_32x16 and then
// serves registered instruction fetches while the CPU runs.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   load_start, load_len  one-cycle request to load load_len words (legal 1..32)
//   in_valid, in_data     upstream byte stream; in_ready accepts a byte
//   rom_enable, pc        fetch strobe and address (honoured only in RUN)
//   instr                 registered instruction, one-cycle fetch latency
//   cpu_run               program loaded, CPU may execute
//   busy                  load in progress (same as in_ready)
//   load_err              last load_start carried an illegal length
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH,
    parameter int unsigned IW    = IMEM_IW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [5:0]               load_len,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     rom_enable,
    input  logic [$clog2(DEPTH)-1:0] pc,
    output logic [IW-1:0]            instr,
    output logic                     cpu_run,
    output logic                     busy,
    output logic                     load_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [1:0] state_q, state_d;
    logic [5:0] len_q, len_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] hi_q, hi_d;
    logic       err_q, err_d;
    logic       mem_we;
    logic       mem_re;

    assign in_ready = (state_q == ST_RECV_HI) || (state_q == ST_RECV_LO);
    assign busy     = in_ready;
    assign cpu_run  = (state_q == ST_RUN);
    assign load_err = err_q;
    assign mem_re   = rom_enable && (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    if (load_len_legal(load_len)) begin
                        len_d   = load_len;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_RECV_HI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RECV_HI: begin
                if (in_valid) begin
                    hi_d    = in_data;
                    state_d = ST_RECV_LO;
                end
            end
            ST_RECV_LO: begin
                if (in_valid) begin
                    // Reset wins over a same-cycle transfer: no write may land
                    mem_we  = !rst;
                    cnt_d   = cnt_q + 6'd1;
                    state_d = (cnt_q == len_q - 6'd1) ? ST_RUN : ST_RECV_HI;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

    imem_32x16 #(
        .DEPTH(DEPTH),
        .IW   (IW)
    ) u_imem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .waddr(cnt_q[AW-1:0]),
        .wdata({hi_q, in_data}),
        .re   (mem_re),
        .raddr(pc),
        .rdata(instr)
    );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: load, backpressure, fetch, illegal lengths,
// reset mid-load and reload from RUN, with hand-computed expectations.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [5:0]  load_len = 6'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        rom_enable = 1'b0;
    logic [4:0]  pc = 5'd0;
    logic [15:0] instr;
    logic        cpu_run;
    logic        busy;
    logic        load_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_mem_loader u_dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .load_len  (load_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rom_enable(rom_enable),
        .pc        (pc),
        .instr     (instr),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .load_err  (load_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [5:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic gap();
        in_valid = 1'b0;
        in_data  = 8'hEE;
        tick();
    endtask

    task automatic fetch(input logic [4:0] addr);
        rom_enable = 1'b1;
        pc         = addr;
        tick();
        rom_enable = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_load_err", load_err, 0);
        check("rst_instr", instr, 0);

        // Load two words with in_valid held
        start_load(6'd2);
        check("ld_in_ready", in_ready, 1);
        check("ld_busy", busy, 1);
        check("ld_err", load_err, 0);
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        check("ld_run_before_last", cpu_run, 0);
        send_byte(8'hD4);
        check("ld_run_after_last", cpu_run, 1);
        check("ld_in_ready_done", in_ready, 0);
        check("ld_busy_done", busy, 0);

        // Fetch path
        fetch(5'd1);
        check("fetch_pc1", instr, 32'hC3D4);
        pc = 5'd0;
        tick();
        check("fetch_hold", instr, 32'hC3D4);
        fetch(5'd0);
        check("fetch_pc0", instr, 32'hA1B2);

        // Reload one word from RUN
        start_load(6'd1);
        check("rl_run_drop", cpu_run, 0);
        check("rl_in_ready", in_ready, 1);
        send_byte(8'h12);
        send_byte(8'h34);
        check("rl_run_back", cpu_run, 1);
        fetch(5'd0);
        check("rl_mem0", instr, 32'h1234);
        fetch(5'd1);
        check("rl_mem1_kept", instr, 32'hC3D4);

        // Backpressure, plus a load_start mid-load that must be ignored
        start_load(6'd2);
        load_start = 1'b1;
        load_len   = 6'd0;
        tick();
        load_start = 1'b0;
        check("bp_ignore_start_err", load_err, 0);
        check("bp_ignore_start_rdy", in_ready, 1);
        send_byte(8'hA1);
        gap();
        send_byte(8'hB2);
        gap();
        send_byte(8'hC3);
        gap();
        check("bp_run_before_last", cpu_run, 0);
        check("bp_in_ready_gap", in_ready, 1);
        send_byte(8'hD4);
        check("bp_run_after_last", cpu_run, 1);
        fetch(5'd0);
        check("bp_mem0", instr, 32'hA1B2);
        fetch(5'd1);
        check("bp_mem1", instr, 32'hC3D4);

        // Illegal lengths
        start_load(6'd0);
        check("il0_err", load_err, 1);
        check("il0_in_ready", in_ready, 0);
        check("il0_run", cpu_run, 0);
        fetch(5'd0);
        check("il0_fetch_blocked", instr, 32'hC3D4);
        start_load(6'd33);
        check("il33_err", load_err, 1);
        check("il33_in_ready", in_ready, 0);
        check("il33_run", cpu_run, 0);

        // Legal start clears the error, then reset after three bytes
        start_load(6'd2);
        check("rm_err_clear", load_err, 0);
        check("rm_in_ready", in_ready, 1);
        send_byte(8'h9A);
        send_byte(8'hBC);
        send_byte(8'hDE);
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hF0;
        load_start = 1'b1;
        load_len   = 6'd1;
        tick();
        rst        = 1'b0;
        in_valid   = 1'b0;
        load_start = 1'b0;
        check("rm_run", cpu_run, 0);
        check("rm_instr", instr, 0);
        check("rm_in_ready", in_ready, 0);
        check("rm_mem0_new", u_dut.u_imem.mem_q[0], 32'h9ABC);
        check("rm_mem1_old", u_dut.u_imem.mem_q[1], 32'hC3D4);

        // Reset beats load_start while in RUN
        start_load(6'd1);
        send_byte(8'h0F);
        send_byte(8'h0E);
        check("rp_run", cpu_run, 1);
        rst        = 1'b1;
        load_start = 1'b1;
        load_len   = 6'd1;
        tick();
        rst        = 1'b0;
        load_start = 1'b0;
        check("rp_in_ready", in_ready, 0);
        check("rp_cpu_run", cpu_run, 0);
        check("rp_mem0", u_dut.u_imem.mem_q[0], 32'h0F0E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
